// File: rtl/branch_resolve_if.sv
// Handshake bundle between the IF target generator / EX branch unit and branch_resolve.
// The DATA_SIZE macro sets the PC width and defaults to 32.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

interface branch_resolve_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
);
  logic                  push;
  logic                  push_taken;
  logic [`DATA_SIZE-1:0] push_target;
  logic [`DATA_SIZE-1:0] push_fallthru;
  logic                  resolve_valid;
  logic                  resolve_taken;
  logic [`DATA_SIZE-1:0] resolve_target;
  logic                  Istall;
  logic                  Dstall;
  logic                  wfi_stall;
  logic                  flush;
  logic [`DATA_SIZE-1:0] redirect_pc;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;
  logic [15:0]           mispredict_cnt;
  logic [15:0]           resolve_cnt;

  modport master (
    output push, push_taken, push_target, push_fallthru,
    output resolve_valid, resolve_taken, resolve_target,
    output Istall, Dstall, wfi_stall,
    input  flush, redirect_pc, count, full, empty,
    input  overflow, underflow, mispredict_cnt, resolve_cnt
  );

  modport slave (
    input  push, push_taken, push_target, push_fallthru,
    input  resolve_valid, resolve_taken, resolve_target,
    input  Istall, Dstall, wfi_stall,
    output flush, redirect_pc, count, full, empty,
    output overflow, underflow, mispredict_cnt, resolve_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch-target queue back end: buffers predictions, resolves the oldest entry, flushes on mispredict.
// Define BRANCH_STAT_EN to implement the mispredict/resolve statistics counters.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

// state | meaning
// IDLE  | accept pushes and resolves
// FLUSH | flush pulse asserted, pipeline loads redirect_pc
// DRAIN | swallow the in-flight wrong-path fetch
module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);
  localparam int DW = `DATA_SIZE;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  state_t          state;
  logic            q_taken    [DEPTH];
  logic [DW-1:0]   q_target   [DEPTH];
  logic [DW-1:0]   q_fallthru [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count_q;
  logic [AW:0]     count_nxt;
  logic            full_q;
  logic            empty_q;
  logic            flush_q;
  logic [DW-1:0]   redirect_q;
  logic            ovf_q;
  logic            unf_q;
  logic            stall;
  logic            head_taken;
  logic [DW-1:0]   head_target;
  logic [DW-1:0]   head_fallthru;
  logic            mispredict;
  logic            do_pop;
  logic            do_push;
  logic            kill;

  always_comb begin
    stall         = bus.Istall | bus.Dstall | bus.wfi_stall;
    head_taken    = q_taken[rd_ptr];
    head_target   = q_target[rd_ptr];
    head_fallthru = q_fallthru[rd_ptr];
    mispredict    = (head_taken != bus.resolve_taken) ||
                    (head_taken && bus.resolve_taken && (head_target != bus.resolve_target));
    do_pop        = !stall && (state == IDLE) && bus.resolve_valid && !empty_q;
    kill          = do_pop && mispredict;
    // a pop in the same cycle frees the slot, so a full queue can still accept
    do_push       = !stall && (state == IDLE) && bus.push && !kill && (!full_q || do_pop);
    count_nxt     = count_q;
    if (kill) begin
      count_nxt = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_nxt = count_q + 1'b1;
        2'b01:   count_nxt = count_q - 1'b1;
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      q_taken[wr_ptr]    <= bus.push_taken;
      q_target[wr_ptr]   <= bus.push_target;
      q_fallthru[wr_ptr] <= bus.push_fallthru;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (!stall) begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == (AW+1)'(DEPTH));
      empty_q <= (count_nxt == '0);
      case (state)
        IDLE: begin
          if (bus.resolve_valid && empty_q)
            unf_q <= 1'b1;
          if (bus.push && full_q && !do_pop)
            ovf_q <= 1'b1;
          if (kill) begin
            state      <= FLUSH;
            flush_q    <= 1'b1;
            redirect_q <= bus.resolve_taken ? bus.resolve_target : head_fallthru;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
          end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
          end
        end
        FLUSH: begin
          flush_q <= 1'b0;
          state   <= DRAIN;
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

`ifdef BRANCH_STAT_EN
  logic [15:0] mis_cnt_q;
  logic [15:0] res_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_cnt_q <= '0;
      res_cnt_q <= '0;
    end else begin
      if (do_pop && (res_cnt_q != 16'hFFFF)) res_cnt_q <= res_cnt_q + 1'b1;
      if (kill && (mis_cnt_q != 16'hFFFF))   mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign bus.mispredict_cnt = mis_cnt_q;
  assign bus.resolve_cnt    = res_cnt_q;
`else
  assign bus.mispredict_cnt = 16'd0;
  assign bus.resolve_cnt    = 16'd0;
`endif
endmodule
